// File: rtl/kzg_pkg.sv
// Shared types and helpers for the K_ZG frame accumulator.
// Saturating add is evaluated at a fixed wide width and clamped to w bits.
package kzg_pkg;

    localparam int Q16_FRAC = 16;
    localparam int SAT_MAXW = 64;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } kzg_state_e;

    typedef struct packed {
        logic signed [SAT_MAXW-1:0] sum;
        logic                       ovf;
    } sat_res_t;

    // a and b must already be sign-extended; w <= SAT_MAXW-1 keeps a+b exact
    function automatic sat_res_t sat_add(
        input logic signed [SAT_MAXW-1:0] a,
        input logic signed [SAT_MAXW-1:0] b,
        input int                         w
    );
        sat_res_t                   r;
        logic signed [SAT_MAXW-1:0] s;
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        s     = a + b;
        hi    = (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
        lo    = ~hi;
        r.sum = s;
        r.ovf = 1'b0;
        if (s > hi) begin
            r.sum = hi;
            r.ovf = 1'b1;
        end else if (s < lo) begin
            r.sum = lo;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/kzg_frame_accumulator_lane.sv
// One signed saturating accumulator lane with sticky overflow.
// Clear wins over enable; the flag only drops on clear or reset.
module sat_acc_lane
    import kzg_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  din,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 ovf
);

    sat_res_t res;
    logic     res_unused;

    always_comb begin
        res = sat_add(
            {{(SAT_MAXW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc},
            {{(SAT_MAXW-IN_WIDTH){din[IN_WIDTH-1]}}, din},
            ACC_WIDTH
        );
    end

    // upper bits are only a sign copy once clamped
    assign res_unused = ^res.sum[SAT_MAXW-1:ACC_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= res.sum[ACC_WIDTH-1:0];
            ovf <= ovf | res.ovf;
        end
    end

endmodule

// File: rtl/kzg_frame_accumulator.sv
// Accumulates N_POINTS K_ZG gradient triples and hands off the
// saturated frame sums on a valid/ready port.
module kzg_frame_accumulator
    import kzg_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 40,
    parameter int N_POINTS  = 64,
    parameter int CNT_WIDTH = $clog2(N_POINTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  kzg_x,
    input  logic [IN_WIDTH-1:0]  kzg_y,
    input  logic [IN_WIDTH-1:0]  kzg_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] sum_x,
    output logic [ACC_WIDTH-1:0] sum_y,
    output logic [ACC_WIDTH-1:0] sum_z,
    output logic                 sum_ovf,
    output logic [15:0]          frame_cnt
);

    kzg_state_e           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 accept;
    logic                 last;
    logic                 hs;
    logic                 lane_clr;
    logic [2:0]           ovf_l;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);

    // clear drops a coincident sample and a coincident handshake
    assign accept   = in_valid & in_ready & ~clear;
    assign last     = accept & (cnt == CNT_WIDTH'(N_POINTS - 1));
    assign hs       = out_valid & out_ready & ~clear;
    assign lane_clr = clear | hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else if (clear || hs) begin
            state <= ACC;
        end else if (last) begin
            state <= HOLD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (lane_clr) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (hs) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    sat_acc_lane #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) lane_x (
        .clk   (clk),
        .rst   (rst),
        .clear (lane_clr),
        .en    (accept),
        .din   (kzg_x),
        .acc   (sum_x),
        .ovf   (ovf_l[0])
    );

    sat_acc_lane #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) lane_y (
        .clk   (clk),
        .rst   (rst),
        .clear (lane_clr),
        .en    (accept),
        .din   (kzg_y),
        .acc   (sum_y),
        .ovf   (ovf_l[1])
    );

    sat_acc_lane #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) lane_z (
        .clk   (clk),
        .rst   (rst),
        .clear (lane_clr),
        .en    (accept),
        .din   (kzg_z),
        .acc   (sum_z),
        .ovf   (ovf_l[2])
    );

    assign sum_ovf = |ovf_l;

endmodule

// File: tb/tb_kzg_frame_accumulator.sv
// Bench for kzg_frame_accumulator: table vectors, directed corner cases
// and random traffic against a frame-level queue model.
module tb_kzg_frame_accumulator;

    localparam int IW  = 32;
    localparam int AW  = 33;
    localparam int NP  = 4;
    localparam int AW1 = 40;

    localparam logic [IW-1:0] ONE  = 32'h0001_0000;
    localparam logic [IW-1:0] MONE = 32'hFFFF_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] kzg_x;
    logic [IW-1:0] kzg_y;
    logic [IW-1:0] kzg_z;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] sum_x;
    logic [AW-1:0] sum_y;
    logic [AW-1:0] sum_z;
    logic          sum_ovf;
    logic [15:0]   frame_cnt;

    logic           u1_in_valid;
    logic           u1_in_ready;
    logic           u1_out_valid;
    logic           u1_out_ready;
    logic [AW1-1:0] u1_sum_x;
    logic [AW1-1:0] u1_sum_y;
    logic [AW1-1:0] u1_sum_z;
    logic           u1_sum_ovf;
    logic [15:0]    u1_frame_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kzg_frame_accumulator #(
        .IN_WIDTH  (IW),
        .ACC_WIDTH (AW),
        .N_POINTS  (NP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kzg_x     (kzg_x),
        .kzg_y     (kzg_y),
        .kzg_z     (kzg_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_x     (sum_x),
        .sum_y     (sum_y),
        .sum_z     (sum_z),
        .sum_ovf   (sum_ovf),
        .frame_cnt (frame_cnt)
    );

    kzg_frame_accumulator #(
        .IN_WIDTH  (IW),
        .ACC_WIDTH (AW1),
        .N_POINTS  (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (u1_in_valid),
        .in_ready  (u1_in_ready),
        .kzg_x     (kzg_x),
        .kzg_y     (kzg_y),
        .kzg_z     (kzg_z),
        .out_valid (u1_out_valid),
        .out_ready (u1_out_ready),
        .sum_x     (u1_sum_x),
        .sum_y     (u1_sum_y),
        .sum_z     (u1_sum_z),
        .sum_ovf   (u1_sum_ovf),
        .frame_cnt (u1_frame_cnt)
    );

    // reference: samples of the current frame and whether it is complete
    longint qx[$];
    longint qy[$];
    longint qz[$];
    bit     m_hold;
    int     m_frames;

    typedef struct {
        logic          vld;
        logic [IW-1:0] x;
        logic [IW-1:0] y;
        logic [IW-1:0] z;
        logic          ordy;
        logic          clr;
        logic          e_ir;
        logic          e_ov;
        logic [AW-1:0] e_sx;
        logic [AW-1:0] e_sy;
        logic [15:0]   e_fc;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic longint fold(input longint q[$], output bit o);
        longint a;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (AW - 1)) - 1;
        lo = -hi - 1;
        a  = 0;
        o  = 1'b0;
        foreach (q[i]) begin
            a = a + q[i];
            if (a > hi) begin
                a = hi;
                o = 1'b1;
            end else if (a < lo) begin
                a = lo;
                o = 1'b1;
            end
        end
        return a;
    endfunction

    task automatic model_reset();
        qx.delete();
        qy.delete();
        qz.delete();
        m_hold   = 1'b0;
        m_frames = 0;
    endtask

    task automatic model_drop();
        qx.delete();
        qy.delete();
        qz.delete();
        m_hold = 1'b0;
    endtask

    task automatic check_model();
        longint        ex;
        longint        ey;
        longint        ez;
        bit            ox;
        bit            oy;
        bit            oz;
        logic [AW-1:0] tx;
        logic [AW-1:0] ty;
        logic [AW-1:0] tz;
        ex = fold(qx, ox);
        ey = fold(qy, oy);
        ez = fold(qz, oz);
        tx = ex[AW-1:0];
        ty = ey[AW-1:0];
        tz = ez[AW-1:0];
        chk("m_in_ready", 64'(in_ready), 64'(!m_hold));
        chk("m_out_valid", 64'(out_valid), 64'(m_hold));
        chk("m_frame_cnt", 64'(frame_cnt), 64'(m_frames[15:0]));
        chk("m_sum_x", 64'(sum_x), 64'(tx));
        chk("m_sum_y", 64'(sum_y), 64'(ty));
        chk("m_sum_z", 64'(sum_z), 64'(tz));
        chk("m_sum_ovf", 64'(sum_ovf), 64'(ox | oy | oz));
    endtask

    task automatic model_step();
        if (clear) begin
            model_drop();
        end else if (m_hold) begin
            if (out_ready) begin
                model_drop();
                m_frames++;
            end
        end else if (in_valid) begin
            qx.push_back(longint'($signed(kzg_x)));
            qy.push_back(longint'($signed(kzg_y)));
            qz.push_back(longint'($signed(kzg_z)));
            if (qx.size() == NP) m_hold = 1'b1;
        end
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] x,
                         input logic [IW-1:0] y, input logic [IW-1:0] z,
                         input logic ordy, input logic clr);
        in_valid  = v;
        kzg_x     = x;
        kzg_y     = y;
        kzg_z     = z;
        out_ready = ordy;
        clear     = clr;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic frame4(input logic [IW-1:0] x, input logic [IW-1:0] y,
                          input logic [IW-1:0] z, input logic ordy);
        for (int i = 0; i < NP; i++) begin
            drive(1'b1, x, y, z, ordy, 1'b0);
            cycle();
        end
    endtask

    initial begin
        int            fc0;
        logic [IW-1:0] r;
        bit            big;
        logic [AW1-1:0] ex1;

        rst          = 1'b1;
        u1_in_valid  = 1'b0;
        u1_out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        tbl[0] = '{1'b1, ONE, MONE, '0, 1'b1, 1'b0, 1'b1, 1'b0,
                   33'h0_0000_0000, 33'h0_0000_0000, 16'd0};
        tbl[1] = '{1'b1, ONE, MONE, '0, 1'b1, 1'b0, 1'b1, 1'b0,
                   33'h0_0001_0000, 33'h1_FFFF_0000, 16'd0};
        tbl[2] = '{1'b1, ONE, MONE, '0, 1'b1, 1'b0, 1'b1, 1'b0,
                   33'h0_0002_0000, 33'h1_FFFE_0000, 16'd0};
        tbl[3] = '{1'b1, ONE, MONE, '0, 1'b1, 1'b0, 1'b1, 1'b0,
                   33'h0_0003_0000, 33'h1_FFFD_0000, 16'd0};
        tbl[4] = '{1'b0, ONE, MONE, '0, 1'b1, 1'b0, 1'b0, 1'b1,
                   33'h0_0004_0000, 33'h1_FFFC_0000, 16'd0};
        tbl[5] = '{1'b0, ONE, MONE, '0, 1'b1, 1'b0, 1'b1, 1'b0,
                   33'h0_0000_0000, 33'h0_0000_0000, 16'd1};

        // basic frame, reset state in row 0
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].vld, tbl[i].x, tbl[i].y, tbl[i].z,
                  tbl[i].ordy, tbl[i].clr);
            settle();
            chk($sformatf("t1_in_ready[%0d]", i), 64'(in_ready),
                64'(tbl[i].e_ir));
            chk($sformatf("t1_out_valid[%0d]", i), 64'(out_valid),
                64'(tbl[i].e_ov));
            chk($sformatf("t1_sum_x[%0d]", i), 64'(sum_x),
                64'(tbl[i].e_sx));
            chk($sformatf("t1_sum_y[%0d]", i), 64'(sum_y),
                64'(tbl[i].e_sy));
            chk($sformatf("t1_sum_z[%0d]", i), 64'(sum_z), 64'd0);
            chk($sformatf("t1_ovf[%0d]", i), 64'(sum_ovf), 64'd0);
            chk($sformatf("t1_fc[%0d]", i), 64'(frame_cnt),
                64'(tbl[i].e_fc));
            advance();
        end

        // back-pressure with a sample offered during HOLD
        frame4(ONE, MONE, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ONE, ONE, ONE, 1'b0, 1'b0);
            settle();
            chk("t2_in_ready", 64'(in_ready), 64'd0);
            chk("t2_sum_x", 64'(sum_x), 64'h4_0000);
            advance();
        end
        drive(1'b1, ONE, ONE, ONE, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        settle();
        chk("t2_fc", 64'(frame_cnt), 64'd2);
        chk("t2_sum_x_zero", 64'(sum_x), 64'd0);
        advance();

        // saturation on both rails, then a clean frame
        frame4(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        settle();
        chk("t3_sum_x", 64'(sum_x), 64'h0_FFFF_FFFF);
        chk("t3_sum_y", 64'(sum_y), 64'h1_0000_0000);
        chk("t3_sum_z", 64'(sum_z), 64'd4);
        chk("t3_ovf", 64'(sum_ovf), 64'd1);
        advance();
        frame4(32'd1, 32'd2, 32'd3, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        settle();
        chk("t3_ovf_next", 64'(sum_ovf), 64'd0);
        chk("t3_sum_x_next", 64'(sum_x), 64'd4);
        advance();

        // clear after two samples, with a sample in the clear cycle
        fc0 = m_frames;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ONE, ONE, ONE, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, ONE, ONE, ONE, 1'b0, 1'b1);
        cycle();
        frame4(ONE, '0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        settle();
        chk("t4_sum_x", 64'(sum_x), 64'h4_0000);
        chk("t4_out_valid", 64'(out_valid), 64'd1);
        advance();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        settle();
        chk("t4_fc", 64'(frame_cnt), 64'(fc0 + 1));
        advance();

        // asynchronous reset between edges, mid-frame
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ONE, ONE, ONE, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_sum_x", 64'(sum_x), 64'd0);
        chk("t5_sum_ovf", 64'(sum_ovf), 64'd0);
        chk("t5_fc", 64'(frame_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        frame4(32'd3, 32'd5, 32'hFFFF_FFF9, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        settle();
        chk("t5_frame_x", 64'(sum_x), 64'd12);
        chk("t5_frame_z", 64'(sum_z), 64'h1_FFFF_FFE4);
        advance();

        // gapped input
        for (int i = 0; i < 8; i++) begin
            drive(i % 2 == 0, ONE, ONE, ONE, 1'b0, 1'b0);
            settle();
            chk($sformatf("t6_out_valid[%0d]", i), 64'(out_valid),
                64'(i == 7));
            advance();
        end
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        settle();
        chk("t6_sum_x", 64'(sum_x), 64'h4_0000);
        advance();

        // single-point frames on the N_POINTS=1 instance
        for (int k = 0; k < 3; k++) begin
            kzg_x        = $urandom;
            kzg_y        = $urandom;
            kzg_z        = $urandom;
            in_valid     = 1'b0;
            out_ready    = 1'b0;
            u1_in_valid  = 1'b1;
            u1_out_ready = 1'b0;
            settle();
            chk("n1_fc", 64'(u1_frame_cnt), 64'(k));
            chk("n1_in_ready", 64'(u1_in_ready), 64'd1);
            chk("n1_out_valid0", 64'(u1_out_valid), 64'd0);
            advance();
            u1_in_valid  = 1'b0;
            u1_out_ready = 1'b1;
            settle();
            ex1 = {{(AW1-IW){kzg_x[IW-1]}}, kzg_x};
            chk("n1_out_valid1", 64'(u1_out_valid), 64'd1);
            chk("n1_sum_x", 64'(u1_sum_x), 64'(ex1));
            ex1 = {{(AW1-IW){kzg_y[IW-1]}}, kzg_y};
            chk("n1_sum_y", 64'(u1_sum_y), 64'(ex1));
            ex1 = {{(AW1-IW){kzg_z[IW-1]}}, kzg_z};
            chk("n1_sum_z", 64'(u1_sum_z), 64'(ex1));
            chk("n1_ovf", 64'(u1_sum_ovf), 64'd0);
            advance();
        end
        u1_out_ready = 1'b0;

        // random traffic against the queue model
        big = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) big = ~big;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 40) == 0);
            r = $urandom;
            kzg_x = big ? r : {{14{r[17]}}, r[17:0]};
            r = $urandom;
            kzg_y = big ? r : {{14{r[17]}}, r[17:0]};
            r = $urandom;
            kzg_z = big ? r : {{14{r[17]}}, r[17:0]};
            cycle();
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
